// File: rtl/t07_tft_pkg.sv
// rtl/t07_tft_pkg.sv - shared types and constants for the TFT byte sequencer
package t07_tft_pkg;

  typedef enum logic [1:0] {
    KIND_CMD    = 2'b00,
    KIND_DATA8  = 2'b01,
    KIND_DATA16 = 2'b10,
    KIND_DELAY  = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_WAIT
  } state_e;

  localparam int unsigned TICKS_PER_MS_DEFAULT = 263;
  localparam int unsigned ENTRY_W = 18;

  typedef struct packed {
    kind_e       kind;
    logic [15:0] word;
  } entry_t;

endpackage

// File: rtl/t07_tft_fifo.sv
// rtl/t07_tft_fifo.sv - synchronous FIFO holding typed words ahead of the sequencer
module t07_tft_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 18
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/t07_tft_byte_sequencer.sv
// rtl/t07_tft_byte_sequencer.sv - splits typed words into D/C-tagged bytes for the SPI TFT serializer
module t07_tft_byte_sequencer
  import t07_tft_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DELAY_W      = 16,
  parameter int unsigned TICKS_PER_MS = TICKS_PER_MS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  in_kind_i,
  input  logic [15:0] in_word_i,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic [7:0]  byte_out_o,
  output logic        dc_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned PRESC_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  state_e               state_q, state_d;
  logic [7:0]           byte_q, byte_d;
  logic [7:0]           lo_q, lo_d;
  logic                 dc_q, dc_d;
  logic [DELAY_W-1:0]   ms_q, ms_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENTRY_W-1:0]   fifo_rdata;
  entry_t               head;

  assign in_ready_o = !fifo_full && !reset_i;
  assign fifo_push  = in_valid_i && in_ready_o;
  assign head       = entry_t'(fifo_rdata);

  t07_tft_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  ({in_kind_i, in_word_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    lo_d     = lo_q;
    dc_d     = dc_q;
    ms_d     = ms_q;
    presc_d  = presc_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (head.kind)
            KIND_CMD: begin
              state_d = ST_SEND_LO;
              byte_d  = head.word[7:0];
              dc_d    = 1'b0;
            end
            KIND_DATA8: begin
              state_d = ST_SEND_LO;
              byte_d  = head.word[7:0];
              dc_d    = 1'b1;
            end
            KIND_DATA16: begin
              state_d = ST_SEND_HI;
              byte_d  = head.word[15:8];
              lo_d    = head.word[7:0];
              dc_d    = 1'b1;
            end
            default: begin
              // A zero-length delay is consumed here without visiting WAIT.
              ms_d    = head.word[DELAY_W-1:0];
              presc_d = '0;
              if (head.word[DELAY_W-1:0] != '0) state_d = ST_WAIT;
            end
          endcase
        end
      end
      ST_SEND_HI: begin
        if (byte_ready_i) begin
          state_d = ST_SEND_LO;
          byte_d  = lo_q;
          dc_d    = 1'b1;
        end
      end
      ST_SEND_LO: begin
        if (byte_ready_i) state_d = ST_IDLE;
      end
      default: begin
        if (presc_q == PRESC_W'(TICKS_PER_MS - 1)) begin
          presc_d = '0;
          ms_d    = ms_q - DELAY_W'(1);
          if (ms_q == DELAY_W'(1)) state_d = ST_IDLE;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
      lo_q    <= '0;
      dc_q    <= 1'b0;
      ms_q    <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      lo_q    <= lo_d;
      dc_q    <= dc_d;
      ms_q    <= ms_d;
      presc_q <= presc_d;
    end
  end

  assign byte_valid_o = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO);
  assign byte_out_o   = byte_q;
  assign dc_o         = dc_q;
  assign busy_o       = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule
